// File: rtl/mfc_ctx_feed_if.sv
// mfc_ctx_feed_if
// Beat stream from the context-window feeder to the DNN input layer.
//   out_data   : current coefficient, MFCBIT bits
//   out_valid  : beat available
//   out_ready  : consumer accepts the beat
//   out_first  : first beat of a window (oldest frame, coefficient 0)
//   out_last   : last beat of a window (newest frame, last coefficient)
// The master modport is the feeder; the slave modport is the DNN side.
interface mfc_ctx_feed_if #(
  parameter int MFCBIT = 32
);
  logic [MFCBIT-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_first;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_first,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_first,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mfc_ctx_feed.sv
// mfc_ctx_feed
// Keeps a circular history of the last CTX packed MFCC frames while speech
// is active and, once the history is full, streams a CTX-frame window
// (oldest frame first, coefficient 0 first) one coefficient per beat.
// One window is produced per accepted frame (stride 1).
//   clk, rst_n : clock, asynchronous active-low reset
//   max        : one-cycle frame strobe from the packer
//   vad        : voice-activity flag, only looked at together with max
//   dat_in     : packed frame, coefficient k at [k*MFCBIT +: MFCBIT]
//   dnn        : beat stream towards the DNN (master side)
//   busy       : high while a window is being streamed
//   drop_cnt   : frames that arrived while streaming, saturates at 255
//   win_cnt    : completed windows, wraps
module mfc_ctx_feed #(
  parameter int MFCBIT = 32,
  parameter int NCOEF  = 12,
  parameter int CTX    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    max,
  input  logic                    vad,
  input  logic [NCOEF*MFCBIT-1:0] dat_in,
  mfc_ctx_feed_if.master          dnn,
  output logic                    busy,
  output logic [7:0]              drop_cnt,
  output logic [15:0]             win_cnt
);

  localparam int PW = $clog2(CTX);
  localparam int CW = $clog2(CTX + 1);
  localparam int XW = $clog2(NCOEF);

  localparam logic [PW-1:0] PTR_LAST  = PW'(CTX - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CTX);
  localparam logic [XW-1:0] COEF_LAST = XW'(NCOEF - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_nxt;

  logic [NCOEF*MFCBIT-1:0] slot [CTX];

  logic [PW-1:0] wr_ptr, wr_ptr_inc;
  logic [PW-1:0] rd_slot, rd_slot_inc;
  logic [PW-1:0] fidx;
  logic [XW-1:0] cidx;
  logic [CW-1:0] cnt, cnt_inc;

  logic accept, flush, fire, coef_end, win_end;

  // Modulo-CTX pointer steps and the saturating fill count.
  always_comb begin
    wr_ptr_inc  = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    rd_slot_inc = (rd_slot == PTR_LAST) ? '0 : rd_slot + 1'b1;
    cnt_inc     = (cnt == CNT_FULL) ? CNT_FULL : cnt + 1'b1;
  end

  // History only changes in IDLE; a strobe while streaming is a drop.
  assign accept   = (state == IDLE) && max && vad;
  assign flush    = (state == IDLE) && max && !vad;
  assign fire     = (state == STREAM) && dnn.out_ready;
  assign coef_end = (cidx == COEF_LAST);
  assign win_end  = coef_end && (fidx == PTR_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start a window when the accepted frame fills the
  // history, return to IDLE on the handshake of the window's last beat.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept && (cnt_inc == CNT_FULL)) state_nxt = STREAM;
      STREAM: if (fire && win_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame storage; contents need no reset because cnt gates their use.
  always_ff @(posedge clk) begin
    if (accept) slot[wr_ptr] <= dat_in;
  end

  // History bookkeeping, read cursor and statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      cnt      <= '0;
      rd_slot  <= '0;
      fidx     <= '0;
      cidx     <= '0;
      drop_cnt <= '0;
      win_cnt  <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        wr_ptr <= wr_ptr_inc;
        cnt    <= cnt_inc;
        if (cnt_inc == CNT_FULL) begin
          // Slot after the newest frame holds the oldest one.
          rd_slot <= wr_ptr_inc;
          fidx    <= '0;
          cidx    <= '0;
        end
      end else if (flush) begin
        wr_ptr <= '0;
        cnt    <= '0;
      end
    end else begin
      if (max && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (fire) begin
        if (coef_end) begin
          cidx    <= '0;
          rd_slot <= rd_slot_inc;
          fidx    <= fidx + 1'b1;
          if (win_end) win_cnt <= win_cnt + 16'd1;
        end else begin
          cidx <= cidx + 1'b1;
        end
      end
    end
  end

  // Beat outputs are decoded from the state so reset clears them at once.
  always_comb begin
    busy          = (state == STREAM);
    dnn.out_valid = (state == STREAM);
    dnn.out_first = (state == STREAM) && (fidx == '0) && (cidx == '0);
    dnn.out_last  = (state == STREAM) && win_end;
    dnn.out_data  = '0;
    if (state == STREAM) dnn.out_data = slot[rd_slot][cidx*MFCBIT +: MFCBIT];
  end

endmodule

// File: tb/tb_mfc_ctx_feed.sv
// tb_mfc_ctx_feed
// Directed/random bench for mfc_ctx_feed. A reference model keeps the frame
// history as a queue and, whenever it fills with no window in flight,
// expands it into the queue of expected beats. Every cycle the DUT outputs
// are compared against the model at the falling clock edge.
module tb_mfc_ctx_feed;

  localparam int MFCBIT = 32;
  localparam int NCOEF  = 12;
  localparam int CTX    = 5;
  localparam int FW     = MFCBIT * NCOEF;
  localparam int WIN    = CTX * NCOEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          max = 1'b0;
  logic          vad = 1'b0;
  logic [FW-1:0] dat_in = '0;
  logic          busy;
  logic [7:0]    drop_cnt;
  logic [15:0]   win_cnt;

  mfc_ctx_feed_if #(.MFCBIT(MFCBIT)) dnn ();

  mfc_ctx_feed #(.MFCBIT(MFCBIT), .NCOEF(NCOEF), .CTX(CTX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .max      (max),
    .vad      (vad),
    .dat_in   (dat_in),
    .dnn      (dnn),
    .busy     (busy),
    .drop_cnt (drop_cnt),
    .win_cnt  (win_cnt)
  );

  always #5 clk = ~clk;

  logic [FW-1:0]     hist[$];
  logic [MFCBIT-1:0] exp_data[$];
  int m_drop = 0;
  int m_win  = 0;
  int n_cmp  = 0;
  int n_err  = 0;

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Compare all DUT outputs against the model's view of this cycle.
  task automatic checkCycle();
    logic expv;
    expv = (exp_data.size() != 0);
    checkOutput("out_valid", dnn.out_valid, expv);
    checkOutput("busy", busy, expv);
    checkOutput("drop_cnt", drop_cnt, m_drop);
    checkOutput("win_cnt", win_cnt, m_win);
    if (expv) begin
      checkOutput("out_data", dnn.out_data, exp_data[0]);
      checkOutput("out_first", dnn.out_first, exp_data.size() == WIN);
      checkOutput("out_last", dnn.out_last, exp_data.size() == 1);
    end
  endtask

  task automatic buildWindow();
    logic [FW-1:0] fr;
    for (int f = 0; f < CTX; f++) begin
      fr = hist[f];
      for (int k = 0; k < NCOEF; k++) exp_data.push_back(fr[k*MFCBIT +: MFCBIT]);
    end
  endtask

  // Effect of one rising edge on the model: a strobe is dropped if a window
  // is in flight, otherwise it extends or flushes the history.
  task automatic modelEdge(input logic m, input logic v, input logic [FW-1:0] f, input logic r);
    logic had;
    had = (exp_data.size() != 0);
    if (m) begin
      if (had) begin
        if (m_drop < 255) m_drop++;
      end else if (v) begin
        hist.push_back(f);
        if (hist.size() > CTX) void'(hist.pop_front());
        if (hist.size() == CTX) buildWindow();
      end else begin
        hist.delete();
      end
    end
    if (had && r) begin
      void'(exp_data.pop_front());
      if (exp_data.size() == 0) m_win = (m_win + 1) % 65536;
    end
  endtask

  // One cycle: check at the falling edge, drive inputs, advance the model.
  task automatic applyStimulus(input logic m, input logic v, input logic [FW-1:0] f, input logic r);
    checkCycle();
    max = m;
    vad = v;
    dat_in = f;
    dnn.out_ready = r;
    modelEdge(m, v, f, r);
    @(negedge clk);
    max = 1'b0;
  endtask

  function automatic logic [FW-1:0] seqFrame(input int n);
    logic [FW-1:0] fr;
    for (int k = 0; k < NCOEF; k++) fr[k*MFCBIT +: MFCBIT] = MFCBIT'(n * 16 + k);
    return fr;
  endfunction

  function automatic logic [FW-1:0] randFrame();
    logic [FW-1:0] fr;
    for (int k = 0; k < NCOEF; k++) fr[k*MFCBIT +: MFCBIT] = $urandom;
    return fr;
  endfunction

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0, 1'b1);
  endtask

  // Run until the expected window is consumed; bounded by a cycle budget.
  task automatic drain(input bit random_ready);
    int guard;
    logic r;
    guard = 0;
    while (exp_data.size() != 0 && guard < 2000) begin
      r = random_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
      applyStimulus(1'b0, 1'b0, '0, r);
      guard++;
    end
  endtask

  initial begin
    dnn.out_ready = 1'b0;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_data", dnn.out_data, 0);
    checkOutput("rst_first", dnn.out_first, 0);
    checkOutput("rst_last", dnn.out_last, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four frames fill the history without producing a window.
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(1'b1, 1'b1, seqFrame(n), 1'b1);
      idle(4);
    end

    // Fifth frame: first window with known beat values.
    applyStimulus(1'b1, 1'b1, seqFrame(5), 1'b1);
    for (int j = 0; j < WIN; j++) begin
      checkOutput("win1_beat", dnn.out_data, (j / 12 + 1) * 16 + j % 12);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
    end
    idle(2);
    checkOutput("win1_count", win_cnt, 1);

    // Sixth frame slides the window to frames 2..6.
    applyStimulus(1'b1, 1'b1, seqFrame(6), 1'b1);
    checkOutput("win2_first", dnn.out_data, 32'h20);
    drain(1'b0);
    idle(2);

    // Random frame, back-pressured consumer.
    applyStimulus(1'b1, 1'b1, randFrame(), 1'b1);
    drain(1'b1);
    idle(3);

    // Flush on vad=0, then the history has to refill from empty.
    applyStimulus(1'b1, 1'b0, randFrame(), 1'b1);
    idle(2);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b1, 1'b1, randFrame(), 1'b1);
      idle(3);
    end
    applyStimulus(1'b1, 1'b1, randFrame(), 1'b1);
    drain(1'b1);
    idle(2);

    // Strobe at beat 10 is dropped; window continues unchanged.
    applyStimulus(1'b1, 1'b1, randFrame(), 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b1, randFrame(), 1'b1);
    drain(1'b0);
    idle(2);
    checkOutput("drop_one", drop_cnt, 1);

    // Strobe on the same edge as the final handshake is also dropped.
    applyStimulus(1'b1, 1'b1, randFrame(), 1'b1);
    while (exp_data.size() > 1) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b1, randFrame(), 1'b1);
    idle(2);

    // Next window excludes the dropped frames.
    applyStimulus(1'b1, 1'b1, randFrame(), 1'b1);
    drain(1'b1);
    idle(2);

    // Many drops under full back-pressure saturate the counter.
    applyStimulus(1'b1, 1'b1, randFrame(), 1'b0);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'b1, ($urandom_range(0, 1) == 1), randFrame(), 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
    end
    checkOutput("drop_sat", drop_cnt, 255);
    drain(1'b0);
    idle(2);

    // Reset in the middle of a window.
    applyStimulus(1'b1, 1'b1, randFrame(), 1'b1);
    repeat (30) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", dnn.out_valid, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_win", win_cnt, 0);
    exp_data.delete();
    hist.delete();
    m_drop = 0;
    m_win = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b1, 1'b1, randFrame(), 1'b1);
      idle(3);
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
